array_max_scanner: RTL and testbench

Bus-initiator engine that drives the data memory's read/write port (address, write_data, Memread, Memwrite) from the requester side. On a start pulse it reads COUNT consecutive 32-bit words from a base address, finds the signed maximum and its zero-based word index, and writes both to the fixed result slots (max at 2000, index at 2004). It sits beside the single-cycle core as an offload for the max-finding test program. It shares the memory port through the top-level mux while busy is high.

---
 rtl/array_max_scanner_pkg.sv | 7 +
 rtl/array_max_scanner_tracker.sv | 33 +++
 rtl/array_max_scanner.sv | 93 +++++++++
 tb/tb_array_max_scanner.sv | 107 ++++++++++
 4 files changed

// File: rtl/array_max_scanner_pkg.sv
// array_max_scanner_pkg: shared state encoding and fixed addresses for the max scanner.
package array_max_scanner_pkg;
   typedef enum logic [2:0] {IDLE, SCAN, WMAX, WIDX, DONE} state_t;
   localparam logic [31:0] MAX_ADDR  = 32'd2000;
   localparam logic [31:0] IDX_ADDR  = 32'd2004;
   localparam logic [31:0] WORD_STEP = 32'd4;
endpackage

// File: rtl/array_max_scanner_tracker.sv
// max_tracker: registered running signed maximum and its index, with clear and first-load.
module max_tracker #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  load,
   input  logic                  first,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [CNT_WIDTH-1:0]  index,
   output logic [DATA_WIDTH-1:0] max_out,
   output logic [DATA_WIDTH-1:0] index_out,
   output logic [DATA_WIDTH-1:0] max_nxt
);
   logic take;
   // strict compare keeps the first occurrence on ties
   always_comb begin
      take    = load && (first || $signed(data) > $signed(max_out));
      max_nxt = clear ? '0 : take ? data : max_out;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         max_out   <= '0;
         index_out <= '0;
      end else begin
         max_out <= max_nxt;
         if (clear) index_out <= '0;
         else if (take) index_out <= DATA_WIDTH'(index);
      end
   end
endmodule

// File: rtl/array_max_scanner.sv
// array_max_scanner: bus-initiator that scans COUNT words for the signed max and writes max/index to fixed slots.
module array_max_scanner
   import array_max_scanner_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  count,
   input  logic [DATA_WIDTH-1:0] read_data,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  Memread,
   output logic                  Memwrite,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] max_out,
   output logic [DATA_WIDTH-1:0] max_index_out
);
   state_t                state;
   logic [CNT_WIDTH-1:0]  n, idx;
   logic [DATA_WIDTH-1:0] max_nxt;
   logic                  clear;
   assign clear = state == IDLE && start && count == '0;
   max_tracker #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_tracker (
      .clk(clk), .rst(rst), .clear(clear), .load(state == SCAN), .first(idx == '0),
      .data(read_data), .index(idx), .max_out(max_out), .index_out(max_index_out),
      .max_nxt(max_nxt)
   );
   // address doubles as the scan pointer while in SCAN
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         n          <= '0;
         idx        <= '0;
         address    <= '0;
         write_data <= '0;
         Memread    <= 1'b0;
         Memwrite   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               busy <= 1'b1;
               if (count != '0) begin
                  state   <= SCAN;
                  n       <= count;
                  idx     <= '0;
                  address <= base_addr;
                  Memread <= 1'b1;
               end else begin
                  state      <= WMAX;
                  address    <= ADDR_WIDTH'(MAX_ADDR);
                  write_data <= '0;
                  Memwrite   <= 1'b1;
               end
            end
            SCAN: if (idx == n - CNT_WIDTH'(1)) begin
               state      <= WMAX;
               Memread    <= 1'b0;
               Memwrite   <= 1'b1;
               address    <= ADDR_WIDTH'(MAX_ADDR);
               write_data <= max_nxt;
            end else begin
               idx     <= idx + CNT_WIDTH'(1);
               address <= address + ADDR_WIDTH'(WORD_STEP);
            end
            WMAX: begin
               state      <= WIDX;
               address    <= ADDR_WIDTH'(IDX_ADDR);
               write_data <= max_index_out;
            end
            WIDX: begin
               state      <= DONE;
               Memwrite   <= 1'b0;
               address    <= '0;
               write_data <= '0;
               done       <= 1'b1;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_array_max_scanner.sv
// tb_array_max_scanner: directed vectors against a word memory model with hand-computed results.
module tb_array_max_scanner;
   logic        clk = 0, rst = 0, start = 0;
   logic [31:0] base_addr = 0, read_data, address, write_data, max_out, max_index_out;
   logic [15:0] count = 0;
   logic        Memread, Memwrite, busy, done;
   logic [31:0] mem [0:1023];
   int          n_vec = 0, n_bad = 0;

   array_max_scanner dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .read_data(read_data), .address(address), .write_data(write_data),
      .Memread(Memread), .Memwrite(Memwrite), .busy(busy), .done(done),
      .max_out(max_out), .max_index_out(max_index_out)
   );

   always #5 clk = ~clk;
   assign read_data = Memread ? mem[address[11:2]] : 32'h0;
   always @(posedge clk) if (Memwrite) mem[address[11:2]] <= write_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run(input logic [31:0] b, input logic [15:0] c, input int restart,
                      input logic [31:0] emax, input logic [31:0] eidx, input string tag);
      int dcyc = -1, reads = 0, writes = 0, both = 0;
      @(negedge clk);
      base_addr = b; count = c; start = 1;
      @(posedge clk);
      #1 start = 0; base_addr = 32'h0000_0F00; count = 16'd9;
      for (int cyc = 1; cyc < 60 && dcyc < 0; cyc++) begin
         @(negedge clk);
         if (Memread && Memwrite) both++;
         if (Memread) begin
            chk({tag, " rd_addr"}, address, b + 32'(reads) * 4);
            reads++;
         end
         if (Memwrite) begin
            chk({tag, " wr_addr"}, address, writes == 0 ? 32'd2000 : 32'd2004);
            chk({tag, " wr_data"}, write_data, writes == 0 ? emax : eidx);
            writes++;
         end
         if (done) dcyc = cyc;
         start = (cyc == restart);
      end
      start = 0;
      chk({tag, " done_cycle"}, 32'(dcyc), 32'(c) + 32'd3);
      chk({tag, " reads"}, 32'(reads), 32'(c));
      chk({tag, " writes"}, 32'(writes), 32'd2);
      chk({tag, " rd_wr_overlap"}, 32'(both), 32'd0);
      chk({tag, " max_out"}, max_out, emax);
      chk({tag, " max_index_out"}, max_index_out, eidx);
      @(negedge clk);
      chk({tag, " mem_max"}, mem[500], emax);
      chk({tag, " mem_idx"}, mem[501], eidx);
      chk({tag, " busy_after"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[0] = 32'd5; mem[1] = -32'sd3; mem[2] = 32'd17; mem[3] = 32'd17;
      mem[25] = -32'sd8; mem[26] = -32'sd2; mem[27] = -32'sd9;
      mem[50] = 32'h7FFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'b0, busy}, 32'd0);
      chk("reset done", {31'b0, done}, 32'd0);
      chk("reset ctrl", {30'b0, Memread, Memwrite}, 32'd0);
      chk("reset address", address, 32'd0);
      chk("reset max", max_out, 32'd0);
      chk("reset idx", max_index_out, 32'd0);
      @(negedge clk) rst = 1;
      run(32'd0, 16'd4, 0, 32'd17, 32'd2, "c1");
      run(32'd100, 16'd3, 0, 32'hFFFF_FFFE, 32'd1, "c2");
      mem[500] = 32'h55; mem[501] = 32'h55;
      run(32'd0, 16'd0, 0, 32'd0, 32'd0, "c3");
      run(32'd200, 16'd1, 0, 32'h7FFF_FFFF, 32'd0, "c4");
      run(32'd0, 16'd4, 2, 32'd17, 32'd2, "c5");
      mem[500] = 32'hDEAD_BEEF;
      @(negedge clk);
      base_addr = 0; count = 4; start = 1;
      @(posedge clk);
      #1 start = 0;
      @(negedge clk);
      @(negedge clk) rst = 0;
      @(posedge clk);
      #1;
      chk("c6 busy", {31'b0, busy}, 32'd0);
      chk("c6 ctrl", {30'b0, Memread, Memwrite}, 32'd0);
      chk("c6 address", address, 32'd0);
      chk("c6 wdata", write_data, 32'd0);
      chk("c6 done", {31'b0, done}, 32'd0);
      chk("c6 max", max_out, 32'd0);
      chk("c6 idx", max_index_out, 32'd0);
      @(negedge clk) rst = 1;
      repeat (6) @(negedge clk);
      chk("c6 no write", mem[500], 32'hDEAD_BEEF);
      run(32'd0, 16'd4, 0, 32'd17, 32'd2, "c6r");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
